// File: rtl/control.sv
// Registered decode/control unit for a DLX-style integer pipeline.
// IF/ID register plus combinational decode, branch-target adder and zero test.
module control #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] instructionin,
  input  logic [WIDTH-1:0] delayin,
  input  logic [WIDTH-1:0] delay2in,
  input  logic [WIDTH-1:0] fwd_a,
  output logic [WIDTH-1:0] delay2out,
  output logic [WIDTH-1:0] branchtarget,
  output logic [WIDTH-1:0] imm32,
  output logic             regdst,
  output logic             alusrc,
  output logic             mem2reg,
  output logic             regwrite,
  output logic             memwrite,
  output logic             branch,
  output logic             jump,
  output logic             loadext,
  output logic             jal,
  output logic             jar,
  output logic [3:0]       aluctrl,
  output logic [1:0]       fpointout,
  output logic [1:0]       dsize,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [4:0]       destreg
);

  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] delay;
  logic [WIDTH-1:0] delay2;
  logic [5:0]       op;
  logic [5:0]       func;
  logic             isbranch;
  logic             extop;
  logic             zero;

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst   <= {WIDTH{1'b0}};
      delay  <= {WIDTH{1'b0}};
      delay2 <= {WIDTH{1'b0}};
    end else begin
      inst   <= instructionin;
      delay  <= delayin;
      delay2 <= delay2in;
    end
  end

  assign op        = inst[31:26];
  assign func      = inst[5:0];
  assign rs1       = inst[25:21];
  assign rs2       = inst[20:16];
  assign rd        = inst[15:11];
  assign delay2out = delay2;
  assign fpointout = 2'b00;

  assign imm32 = extop ? {{(WIDTH-16){inst[15]}}, inst[15:0]}
                       : {{(WIDTH-16){1'b0}}, inst[15:0]};
  // Word-aligned target; carry-out is dropped by the fixed-width sum
  assign branchtarget = delay + {imm32[WIDTH-1:2], 2'b00};

  assign zero    = (fwd_a == {WIDTH{1'b0}});
  assign branch  = isbranch & (inst[26] ? ~zero : zero);
  assign destreg = jal ? 5'd31 : (regdst ? rd : rs2);

  // Opcode/function decode; anything not recognised stays a NOP
  always_comb begin
    regdst   = 1'b0;
    alusrc   = 1'b0;
    mem2reg  = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    jump     = 1'b0;
    loadext  = 1'b0;
    jal      = 1'b0;
    jar      = 1'b0;
    aluctrl  = 4'd0;
    dsize    = 2'b00;
    isbranch = 1'b0;
    extop    = 1'b0;
    case (op)
      6'h00: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        case (func)
          6'h20, 6'h21: aluctrl = 4'd0;
          6'h22, 6'h23: aluctrl = 4'd1;
          6'h24:        aluctrl = 4'd2;
          6'h25:        aluctrl = 4'd3;
          6'h26:        aluctrl = 4'd4;
          6'h04:        aluctrl = 4'd5;
          6'h06:        aluctrl = 4'd6;
          6'h07:        aluctrl = 4'd7;
          6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D:
                        aluctrl = 4'd8 + {1'b0, func[2:0]};
          default: begin
            regdst   = 1'b0;
            regwrite = 1'b0;
          end
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h14, 6'h16, 6'h17,
      6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: begin
        alusrc   = 1'b1;
        regwrite = 1'b1;
        case (op)
          6'h08:        begin aluctrl = 4'd0; extop = 1'b1; end
          6'h09:        aluctrl = 4'd0;
          6'h0A:        begin aluctrl = 4'd1; extop = 1'b1; end
          6'h0B:        aluctrl = 4'd1;
          6'h0C:        aluctrl = 4'd2;
          6'h0D:        aluctrl = 4'd3;
          6'h0E:        aluctrl = 4'd4;
          6'h0F:        aluctrl = 4'd14;
          6'h14:        aluctrl = 4'd5;
          6'h16:        aluctrl = 4'd6;
          6'h17:        aluctrl = 4'd7;
          default: begin
            aluctrl = 4'd8 + {1'b0, op[2:0]};
            extop   = 1'b1;
          end
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        alusrc   = 1'b1;
        mem2reg  = 1'b1;
        regwrite = 1'b1;
        extop    = 1'b1;
        loadext  = (op == 6'h20) || (op == 6'h21);
        case (op)
          6'h20, 6'h24: dsize = 2'b10;
          6'h21, 6'h25: dsize = 2'b01;
          default:      dsize = 2'b00;
        endcase
      end
      6'h28, 6'h29, 6'h2B: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
        extop    = 1'b1;
        case (op)
          6'h28:   dsize = 2'b10;
          6'h29:   dsize = 2'b01;
          default: dsize = 2'b00;
        endcase
      end
      6'h04, 6'h05: begin
        isbranch = 1'b1;
        extop    = 1'b1;
      end
      6'h02: jump = 1'b1;
      6'h03: begin
        jump     = 1'b1;
        jal      = 1'b1;
        regwrite = 1'b1;
      end
      6'h12: jar = 1'b1;
      6'h13: begin
        jar      = 1'b1;
        jal      = 1'b1;
        regwrite = 1'b1;
      end
      default: begin
        extop = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: table of decode vectors fed through a
// scoreboard queue, plus hand-written reset and branch-resolution sequences.
module tb_control;

  logic        clk;
  logic        rst_n;
  logic [31:0] instructionin, delayin, delay2in, fwd_a;
  logic [31:0] delay2out, branchtarget, imm32;
  logic        regdst, alusrc, mem2reg, regwrite, memwrite, branch;
  logic        jump, loadext, jal, jar;
  logic [3:0]  aluctrl;
  logic [1:0]  fpointout, dsize;
  logic [4:0]  rs1, rs2, rd, destreg;

  int checks;
  int errors;

  control #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .instructionin(instructionin), .delayin(delayin), .delay2in(delay2in),
    .fwd_a(fwd_a), .delay2out(delay2out), .branchtarget(branchtarget),
    .imm32(imm32), .regdst(regdst), .alusrc(alusrc), .mem2reg(mem2reg),
    .regwrite(regwrite), .memwrite(memwrite), .branch(branch), .jump(jump),
    .loadext(loadext), .jal(jal), .jar(jar), .aluctrl(aluctrl),
    .fpointout(fpointout), .dsize(dsize), .rs1(rs1), .rs2(rs2), .rd(rd),
    .destreg(destreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl = {regdst,alusrc,mem2reg,regwrite,memwrite,branch,jump,loadext,jal,jar}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] dly;
    logic [31:0] fa;
    logic [9:0]  ctrl;
    logic [3:0]  alu;
    logic [1:0]  ds;
    logic [4:0]  dst;
    logic [31:0] imm;
    logic [31:0] bt;
  } vec_t;

  vec_t vecs[22];
  vec_t sb[$];

  function automatic logic [9:0] obs_ctrl();
    return {regdst, alusrc, mem2reg, regwrite, memwrite, branch, jump, loadext, jal, jar};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t e);
    chk("ctrl", idx, {54'd0, obs_ctrl()}, {54'd0, e.ctrl});
    chk("alu_ds_fp_dst", idx, {51'd0, aluctrl, dsize, fpointout, destreg},
        {51'd0, e.alu, e.ds, 2'b00, e.dst});
    chk("imm32", idx, {32'd0, imm32}, {32'd0, e.imm});
    chk("branchtarget", idx, {32'd0, branchtarget}, {32'd0, e.bt});
    chk("delay2out", idx, {32'd0, delay2out}, {32'd0, e.dly + 32'd4});
  endtask

  initial begin
    vec_t e;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    instructionin = 32'h0;
    delayin = 32'h0;
    delay2in = 32'h0;
    fwd_a = 32'h0;

    //           instr         dly           fwd_a         ctrl           alu    ds     dst    imm           bt
    vecs[0]  = '{32'h2001FFFF, 32'h00000100, 32'h00000000, 10'b0101000000, 4'd0,  2'b00, 5'd1,  32'hFFFFFFFF, 32'h000000FC};
    vecs[1]  = '{32'h10400008, 32'h00000100, 32'h00000000, 10'b0000010000, 4'd0,  2'b00, 5'd0,  32'h00000008, 32'h00000108};
    vecs[2]  = '{32'h10400008, 32'h00000100, 32'h00000005, 10'b0000000000, 4'd0,  2'b00, 5'd0,  32'h00000008, 32'h00000108};
    vecs[3]  = '{32'h14400008, 32'h00000100, 32'h00000000, 10'b0000000000, 4'd0,  2'b00, 5'd0,  32'h00000008, 32'h00000108};
    vecs[4]  = '{32'h14400008, 32'h00000100, 32'hFFFFFFFF, 10'b0000010000, 4'd0,  2'b00, 5'd0,  32'h00000008, 32'h00000108};
    vecs[5]  = '{32'h00221822, 32'h00000100, 32'h00000000, 10'b1001000000, 4'd1,  2'b00, 5'd3,  32'h00001822, 32'h00001920};
    vecs[6]  = '{32'h9025FFFC, 32'h00000100, 32'h00000000, 10'b0111000000, 4'd0,  2'b10, 5'd5,  32'hFFFFFFFC, 32'h000000FC};
    vecs[7]  = '{32'h80250010, 32'h00000100, 32'h00000000, 10'b0111000100, 4'd0,  2'b10, 5'd5,  32'h00000010, 32'h00000110};
    vecs[8]  = '{32'h84250010, 32'h00000100, 32'h00000000, 10'b0111000100, 4'd0,  2'b01, 5'd5,  32'h00000010, 32'h00000110};
    vecs[9]  = '{32'hAC260008, 32'h00000100, 32'h00000000, 10'b0100100000, 4'd0,  2'b00, 5'd6,  32'h00000008, 32'h00000108};
    vecs[10] = '{32'hA0260008, 32'h00000100, 32'h00000000, 10'b0100100000, 4'd0,  2'b10, 5'd6,  32'h00000008, 32'h00000108};
    vecs[11] = '{32'h0C000040, 32'h00000100, 32'h00000000, 10'b0001001010, 4'd0,  2'b00, 5'd31, 32'h00000040, 32'h00000140};
    vecs[12] = '{32'h48600000, 32'h00000100, 32'h00000000, 10'b0000000001, 4'd0,  2'b00, 5'd0,  32'h00000000, 32'h00000100};
    vecs[13] = '{32'h4C600000, 32'h00000100, 32'h00000000, 10'b0001000011, 4'd0,  2'b00, 5'd31, 32'h00000000, 32'h00000100};
    vecs[14] = '{32'h3C048000, 32'h00000100, 32'h00000000, 10'b0101000000, 4'd14, 2'b00, 5'd4,  32'h00008000, 32'h00008100};
    vecs[15] = '{32'h3427FFFF, 32'h00000100, 32'h00000000, 10'b0101000000, 4'd3,  2'b00, 5'd7,  32'h0000FFFF, 32'h000100FC};
    vecs[16] = '{32'h7422FFFE, 32'h00000100, 32'h00000000, 10'b0101000000, 4'd13, 2'b00, 5'd2,  32'hFFFFFFFE, 32'h000000FC};
    vecs[17] = '{32'h00221800, 32'h00000100, 32'h00000000, 10'b0000000000, 4'd0,  2'b00, 5'd2,  32'h00001800, 32'h00001900};
    vecs[18] = '{32'h00221807, 32'h00000100, 32'h00000000, 10'b1001000000, 4'd7,  2'b00, 5'd3,  32'h00001807, 32'h00001904};
    vecs[19] = '{32'h0022182A, 32'h00000100, 32'h00000000, 10'b1001000000, 4'd10, 2'b00, 5'd3,  32'h0000182A, 32'h00001928};
    vecs[20] = '{32'hFC000004, 32'h00000100, 32'h00000000, 10'b0000000000, 4'd0,  2'b00, 5'd0,  32'h00000004, 32'h00000104};
    vecs[21] = '{32'h10400008, 32'hFFFFFFFC, 32'h00000000, 10'b0000010000, 4'd0,  2'b00, 5'd0,  32'h00000008, 32'h00000004};

    // Reset state decodes as NOP
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 0, {54'd0, obs_ctrl()}, 64'd0);
    chk("reset_words", 0, {delay2out, branchtarget}, 64'd0);
    rst_n = 1'b1;

    // Table vectors through the scoreboard: push on drive, pop on capture
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      instructionin = vecs[i].instr;
      delayin = vecs[i].dly;
      delay2in = vecs[i].dly + 32'd4;
      fwd_a = vecs[i].fa;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", i, 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_vec(i, e);
      end
    end

    // One-cycle latency: new input must not appear before the clock edge
    @(negedge clk);
    instructionin = 32'h00000000;
    delay2in = 32'h12345678;
    #2;
    chk("latency_hold", 0, {22'd0, obs_ctrl(), delay2out}, {22'd0, 10'b0000010000, 32'h00000000});
    @(posedge clk);
    #1;
    chk("latency_take", 0, {22'd0, obs_ctrl(), delay2out}, {22'd0, 10'b0000000000, 32'h12345678});

    // BEQZ held: branch follows fwd_a combinationally with no clock edge
    @(negedge clk);
    instructionin = 32'h10400008;
    fwd_a = 32'h0;
    @(posedge clk);
    #1;
    chk("beqz_zero", 0, {63'd0, branch}, 64'd1);
    fwd_a = 32'h80000000;
    #1;
    chk("beqz_nonzero", 0, {63'd0, branch}, 64'd0);
    fwd_a = 32'h00000001;
    #1;
    chk("beqz_lsb", 0, {63'd0, branch}, 64'd0);

    // Asynchronous reset mid-cycle clears everything without a clock edge
    @(negedge clk);
    instructionin = 32'h2001FFFF;
    delay2in = 32'hCAFEF00D;
    delayin = 32'h00000200;
    @(posedge clk);
    #1;
    chk("pre_reset", 0, {22'd0, obs_ctrl(), delay2out}, {22'd0, 10'b0101000000, 32'hCAFEF00D});
    #2;
    instructionin = 32'h20010005;
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", 0, {50'd0, obs_ctrl(), aluctrl}, 64'd0);
    chk("async_reset_words", 0, {delay2out, imm32}, 64'd0);
    chk("async_reset_bt_dst", 0, {27'd0, branchtarget, destreg}, 64'd0);
    @(posedge clk);
    #1;
    chk("reset_held", 0, {22'd0, obs_ctrl(), delay2out}, 64'd0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control.md
Name: control

Overview:
- Registered decode/control unit for the integer pipeline (DLX-style 32-bit ISA).
- Captures the fetched instruction and its two PC-delay words into an IF/ID register.
- Decodes the registered instruction into datapath control signals.
- Computes the branch target (internal 32-bit adder) and resolves BEQZ/BNEZ (internal zero-equality compare) on the forwarded A operand.

Parameters:
- WIDTH, 32, datapath/word width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instructionin  in  32  fetched instruction
- delayin  in  32  PC+4 of fetched instruction
- delay2in  in  32  PC+8 (link value)
- fwd_a  in  32  forwarded rs1 operand for branch test
- delay2out  out  32  registered delay2in
- branchtarget  out  32  delay + (imm32 with bits[1:0] cleared)
- imm32  out  32  extended immediate
- regdst, alusrc, mem2reg, regwrite, memwrite, branch, jump, loadext, jal, jar  out  1 each  control
- aluctrl  out  4  ALU op
- fpointout  out  2  register-file select
- dsize  out  2  memory size: 00 word, 01 half, 10 byte
- rs1  out  5  instr[25:21]
- rs2  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- destreg  out  5  regdst ? rd : rs2

Behaviour:
- IF/ID register
  - On rising clk: inst <= instructionin; delay <= delayin; delay2 <= delay2in.
  - When rst_n is low, all three clear to 0 immediately, regardless of clk.
  - All other outputs are combinational from these registers and fwd_a. Latency is one cycle from inputs to decode.
  - Reset state is inst=0, which decodes as NOP: all control outputs 0, aluctrl=0, dsize=00.
- Fields
  - op = inst[31:26]; func = inst[5:0].
  - imm32 = extop ? sign-extend(inst[15:0]) : zero-extend(inst[15:0]).
  - extop=1 for signed arithmetic immediates (ADDI, SUBI), set-immediates, loads, stores and branches; extop=0 otherwise.
- branchtarget = delay + {imm32[31:2],2'b00}, modulo 2^32. Carry-out is discarded.
- Branch resolution
  - zero = (fwd_a == 0).
  - branch = isbranch & (inst[26] ? ~zero : zero). BEQZ has op 0x04; BNEZ has op 0x05.
- aluctrl codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SEQ, 9 SNE, 10 SLT, 11 SGT, 12 SLE, 13 SGE, 14 LHI (imm<<16).
- R-type (op 0x00)
  - regdst=1, regwrite=1, alusrc=0.
  - aluctrl from func: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x04 SLL, 0x06 SRL, 0x07 SRA, 0x28–0x2D SEQ..SGE.
  - func 0 or any unlisted func decodes as NOP: all controls 0.
- Immediate ALU
  - alusrc=1, regwrite=1, regdst=0.
  - Ops: ADDI 0x08, ADDUI 0x09, SUBI 0x0A, SUBUI 0x0B, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LHI 0x0F, SLLI 0x14, SRLI 0x16, SRAI 0x17, SEQI..SGEI 0x18–0x1D.
- Loads
  - Ops: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - alusrc=1, mem2reg=1, regwrite=1, aluctrl=ADD.
  - loadext=1 for LB/LH; 0 for unsigned loads and LW.
- Stores
  - Ops: SB 0x28, SH 0x29, SW 0x2B.
  - alusrc=1, memwrite=1, aluctrl=ADD, regwrite=0.
- Branches BEQZ/BNEZ: isbranch=1, no writes.
- Jumps
  - J 0x02: jump=1.
  - JAL 0x03: jump=1, jal=1, regwrite=1, destreg forced to 31.
  - JR 0x12: jar=1.
  - JALR 0x13: jar=1, jal=1, regwrite=1, destreg=31.
- fpointout = 00 for every op. Any unlisted opcode decodes as NOP.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with instructionin=0x20010005 -> delay2out=0, every control output 0, immediately without waiting for a clk edge.
- ADDI R1,R0,-1 (0x2001FFFF) clocked in -> next cycle: regwrite=1, alusrc=1, aluctrl=0, imm32=0xFFFFFFFF, destreg=1.
- BEQZ R2,+8 (0x10400008) with delayin=0x100 -> branchtarget=0x108. fwd_a=0 gives branch=1; fwd_a=5 gives branch=0.
- BNEZ (0x14400008) -> fwd_a=0 gives branch=0; fwd_a=0xFFFFFFFF gives branch=1.
- R-type SUB R3,R1,R2 (0x00221822) -> regdst=1, destreg=3, aluctrl=1.
- LBU (op 0x24) -> loadext=0, dsize=10. SW (op 0x2B) -> memwrite=1, regwrite=0, dsize=00. JAL -> jal=1, jump=1, destreg=31.
